wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DEPTH, default 4, write-back queue depth in entries; legal values are powers of two, 2..16.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid_i  input  1  the ALU result on alu_r_i/alu_data_i is valid this cycle.
REQ-005 alu_r_i  input  4  ALU destination register address.
REQ-006 alu_data_i  input  32  ALU result data.
REQ-007 ld_valid_i  input  1  the load result on ld_r_i/ld_data_i is valid this cycle.
REQ-008 ld_r_i  input  4  load destination register address.
REQ-009 ld_data_i  input  32  load result data.
REQ-010 stall_o  output  1  back-pressure to both producers; 1 means the producer holds its result.
REQ-011 wb_o  output  1  register-file write enable; registered.
REQ-012 wb_r_o  output  4  register-file write address; registered.
REQ-013 wb_data_o  output  32  register-file write data; registered.

Function
REQ-014 The queue SHALL be a circular FIFO of DEPTH entries {r[3:0], data[31:0]}, with head and tail pointers that wrap modulo DEPTH, and a count from 0 to DEPTH.
REQ-015 stall_o SHALL be combinational: 1 when count > DEPTH-2 (fewer than 2 free slots), else 0.
REQ-016 The block SHALL ignore inputs presented while stall_o=1; producers hold them until stall_o=0.
REQ-017 Each cycle the block SHALL drive the write port from exactly one source, in priority order: FIFO head if count>0; else ld input if valid; else alu input if valid; else wb_o<=0.
REQ-018 Empty FIFO, single valid input: that input SHALL reach wb_o/wb_r_o/wb_data_o on the next edge, a 1-cycle latency.
REQ-019 Empty FIFO, both inputs valid: ld SHALL be written back directly and alu enqueued, so alu writes back 1 cycle after ld.
REQ-020 Non-empty FIFO: accepted inputs SHALL be enqueued in the same cycle as the head pop, ld ahead of alu when both are valid, so write-back order equals arrival order.
REQ-021 The block SHALL perform push and pop in the same cycle; count changes by pushes minus pops.
REQ-022 When wb_o=0, wb_r_o and wb_data_o SHALL hold their previous values.
REQ-023 The block SHALL write back every accepted result exactly once, with no merging and no dropping, even when addresses are equal, because each write-back releases one register reservation.
REQ-024 Two results with equal addresses SHALL write back in arrival order, so the later value wins.
REQ-025 Overflow is impossible by REQ-015; the block asserts on push when full in simulation only.

Reset
REQ-026 While rst=0, the block SHALL set wb_o=0, wb_r_o=0, wb_data_o=0, head=tail=0 and count=0, so stall_o=0.
REQ-027 A reset mid-operation SHALL discard every queued entry without any write-back; the first cycle after rst rises is an idle cycle with wb_o=0.

Configuration
REQ-028 Macro WB_PERF_EN SHALL control the stall counter.
- Defined: output perf_stall_o [15:0] counts the cycles with stall_o=1, saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Verification
REQ-029 Scenario: single ALU result, alu r=3, data=32'h1234 at cycle 0 on an empty FIFO -> wb_o=1, wb_r_o=3, wb_data_o=32'h1234 after edge 1 and wb_o=0 after edge 2.
REQ-030 Scenario: simultaneous inputs, ld r=5, d=32'hA and alu r=6, d=32'hB on an empty FIFO -> r5 written back at edge 1, r6 at edge 2, stall_o=0 throughout.
REQ-031 Scenario: back-pressure, both inputs valid every cycle with DEPTH=4 -> stall_o=1 once count reaches 3; no result lost; write-back order equals arrival order (ld before alu within each cycle).
REQ-032 Scenario: same address, ld r=2, d=1 then alu r=2, d=2 -> two write-backs to r2, values 1 then 2.
REQ-033 Scenario: reset mid-operation, rst=0 with count=3 -> wb_o=0 and stall_o=0 immediately; queued entries never appear on the write port.
REQ-034 Scenario (WB_PERF_EN): stall held for 20 cycles -> perf_stall_o=20; counter held at 16'hFFFF after 70000 stall cycles.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back arbitration stage with a small circular queue.
// Merges the ALU and load result streams onto one register-file write port.
// Results leave in arrival order, with load ahead of ALU when both arrive
// in the same cycle. Each accepted result is written back exactly once.
// Optional feature: define WB_PERF_EN to add perf_stall_o, a saturating
// count of stalled cycles.
module wb_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid_i,
    input  logic [3:0]  alu_r_i,
    input  logic [31:0] alu_data_i,
    input  logic        ld_valid_i,
    input  logic [3:0]  ld_r_i,
    input  logic [31:0] ld_data_i,
    output logic        stall_o,
    output logic        wb_o,
    output logic [3:0]  wb_r_o,
    output logic [31:0] wb_data_o
`ifdef WB_PERF_EN
    ,
    output logic [15:0] perf_stall_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    mem_r_reg [DEPTH];
    logic [31:0]   mem_d_reg [DEPTH];
    logic [PW-1:0] head_reg, tail_reg, tail_plus1;
    logic [CW-1:0] count_reg, count_next;

    logic          ld_acc, alu_acc, pop;
    logic          p0_v, p1_v;
    logic [3:0]    p0_r, p1_r;
    logic [31:0]   p0_d, p1_d;
    logic [1:0]    push_n;
    logic          wb_next;
    logic [3:0]    wb_r_next;
    logic [31:0]   wb_data_next;

    // Keep two free slots so that a full two-result cycle can always be absorbed
    assign stall_o    = (count_reg > CW'(DEPTH - 2));
    assign ld_acc     = ld_valid_i  & ~stall_o;
    assign alu_acc    = alu_valid_i & ~stall_o;
    assign tail_plus1 = tail_reg + PW'(1);
    assign push_n     = {1'b0, p0_v} + {1'b0, p1_v};
    assign count_next = count_reg + CW'(push_n) - CW'(pop);

    // Select the write-port source and decide which accepted results get queued
    always_comb begin
        wb_next      = 1'b0;
        wb_r_next    = wb_r_o;
        wb_data_next = wb_data_o;
        pop          = 1'b0;
        p0_v         = 1'b0;
        p0_r         = ld_r_i;
        p0_d         = ld_data_i;
        p1_v         = 1'b0;
        p1_r         = alu_r_i;
        p1_d         = alu_data_i;
        if (count_reg != '0) begin
            // Older queued work goes first; new arrivals line up behind it
            wb_next      = 1'b1;
            wb_r_next    = mem_r_reg[head_reg];
            wb_data_next = mem_d_reg[head_reg];
            pop          = 1'b1;
            if (ld_acc) begin
                p0_v = 1'b1;
                p1_v = alu_acc;
            end else if (alu_acc) begin
                p0_v = 1'b1;
                p0_r = alu_r_i;
                p0_d = alu_data_i;
            end
        end else if (ld_acc) begin
            // Load bypasses the empty queue; a same-cycle ALU result waits one cycle
            wb_next      = 1'b1;
            wb_r_next    = ld_r_i;
            wb_data_next = ld_data_i;
            p0_v         = alu_acc;
            p0_r         = alu_r_i;
            p0_d         = alu_data_i;
        end else if (alu_acc) begin
            wb_next      = 1'b1;
            wb_r_next    = alu_r_i;
            wb_data_next = alu_data_i;
        end
    end

    // Queue storage: the first push lands at tail, the second at tail+1
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Write this slot when either push targets it
            always_ff @(posedge clk) begin
                if (p0_v && tail_reg == PW'(gi)) begin
                    mem_r_reg[gi] <= p0_r;
                    mem_d_reg[gi] <= p0_d;
                end else if (p1_v && tail_plus1 == PW'(gi)) begin
                    mem_r_reg[gi] <= p1_r;
                    mem_d_reg[gi] <= p1_d;
                end
            end
        end
    endgenerate

    // Pointer, occupancy and write-port registers; reset discards queued entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            wb_o      <= 1'b0;
            wb_r_o    <= '0;
            wb_data_o <= '0;
        end else begin
            head_reg  <= head_reg + PW'(pop);
            tail_reg  <= tail_reg + PW'(push_n);
            count_reg <= count_next;
            wb_o      <= wb_next;
            wb_r_o    <= wb_r_next;
            wb_data_o <= wb_data_next;
        end
    end

`ifndef SYNTHESIS
    // Occupancy must never exceed the queue depth
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (int'(count_reg) + int'(push_n) - int'(pop) <= DEPTH);
        end
    end
`endif

`ifdef WB_PERF_EN
    // Saturating count of cycles spent applying back-pressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_o <= '0;
        end else if (stall_o && perf_stall_o != 16'hFFFF) begin
            perf_stall_o <= perf_stall_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage (DEPTH=4): single results, simultaneous
// results, back-pressure ordering, equal addresses and reset mid-operation.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid;
    logic [3:0]  alu_r, ld_r;
    logic [31:0] alu_data, ld_data;
    logic        stall, wb;
    logic [3:0]  wb_r;
    logic [31:0] wb_data;
`ifdef WB_PERF_EN
    logic [15:0] perf_stall;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
    } wb_t;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    wb_stage #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid),
        .alu_r_i     (alu_r),
        .alu_data_i  (alu_data),
        .ld_valid_i  (ld_valid),
        .ld_r_i      (ld_r),
        .ld_data_i   (ld_data),
        .stall_o     (stall),
        .wb_o        (wb),
        .wb_r_o      (wb_r),
        .wb_data_o   (wb_data)
`ifdef WB_PERF_EN
        ,
        .perf_stall_o(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic set_ld(input logic [3:0] r, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_r     = r;
        ld_data  = d;
    endtask

    task automatic set_alu(input logic [3:0] r, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_r     = r;
        alu_data  = d;
    endtask

    // Compare an observed write-back against the oldest expected result
    task automatic check_wb(input string tag);
        wb_t e;
        if (wb) begin
            $display("wb r=%0d data=%08h", wb_r, wb_data);
            if (exp_q.size() == 0) begin
                check({tag, "_extra"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_r"}, 32'(wb_r), 32'(e.r));
                check({tag, "_d"}, wb_data, e.d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int stall_cycles;
        wb_t e;
        bit  done;

        idle_inputs();
        alu_r = '0; alu_data = '0; ld_r = '0; ld_data = '0;
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_wb",    32'(wb),      32'd0);
        check("rst_r",     32'(wb_r),    32'd0);
        check("rst_data",  wb_data,      32'd0);
        check("rst_stall", 32'(stall),   32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single ALU result, 1-cycle latency then idle with held address/data
        set_alu(4'd3, 32'h1234);
        tick();
        idle_inputs();
        $display("single alu r=3 data=1234");
        check("alu_wb",   32'(wb),    32'd1);
        check("alu_r",    32'(wb_r),  32'd3);
        check("alu_data", wb_data,    32'h1234);
        tick();
        check("alu_idle_wb",   32'(wb),   32'd0);
        check("alu_hold_r",    32'(wb_r), 32'd3);
        check("alu_hold_data", wb_data,   32'h1234);

        // Simultaneous load and ALU: load first, ALU one cycle later, no stall
        set_ld(4'd5, 32'hA);
        set_alu(4'd6, 32'hB);
        #1;
        check("sim_stall0", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        $display("simultaneous ld r=5, alu r=6");
        check("sim_wb1",    32'(wb),    32'd1);
        check("sim_r1",     32'(wb_r),  32'd5);
        check("sim_d1",     wb_data,    32'hA);
        check("sim_stall1", 32'(stall), 32'd0);
        tick();
        check("sim_wb2",    32'(wb),    32'd1);
        check("sim_r2",     32'(wb_r),  32'd6);
        check("sim_d2",     wb_data,    32'hB);
        check("sim_stall2", 32'(stall), 32'd0);
        tick();
        check("sim_idle", 32'(wb), 32'd0);

        // Equal addresses: both write back, later value last
        set_ld(4'd2, 32'd1);
        tick();
        idle_inputs();
        set_alu(4'd2, 32'd2);
        $display("same address r=2, values 1 then 2");
        check("same_wb1", 32'(wb),   32'd1);
        check("same_r1",  32'(wb_r), 32'd2);
        check("same_d1",  wb_data,   32'd1);
        tick();
        idle_inputs();
        check("same_wb2", 32'(wb),   32'd1);
        check("same_r2",  32'(wb_r), 32'd2);
        check("same_d2",  wb_data,   32'd2);
        tick();
        check("same_idle", 32'(wb), 32'd0);

        // Back-pressure: both producers busy every cycle.
        // Occupancy from empty: 0,1,2,3,2,3,2,... so stall is 1 on cycles 3,5,7,...
        k = 0;
        stall_cycles = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            set_ld(4'(k), 32'h1000 + 32'(k));
            set_alu(4'(k + 8), 32'h2000 + 32'(k));
            #1;
            check($sformatf("bp_stall%0d", cyc), 32'(stall),
                  32'((cyc >= 3) && (cyc % 2 == 1)));
            if (!stall) begin
                e.r = ld_r;  e.d = ld_data;  exp_q.push_back(e);
                e.r = alu_r; e.d = alu_data; exp_q.push_back(e);
                k++;
            end else begin
                stall_cycles++;
            end
            tick();
            check_wb($sformatf("bp%0d", cyc));
        end
        idle_inputs();
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            check_wb($sformatf("drain%0d", i));
            if (exp_q.size() == 0 && !wb) done = 1'b1;
        end
        check("bp_accepted", 32'(k), 32'd7);
        check("bp_left",     32'(exp_q.size()), 32'd0);
        check("bp_idle",     32'(wb), 32'd0);
`ifdef WB_PERF_EN
        check("perf_stall", 32'(perf_stall), 32'(stall_cycles));
`endif

        // Reset mid-operation with three entries queued
        for (int cyc = 0; cyc < 3; cyc++) begin
            set_ld(4'd9, 32'hDEAD0000 + 32'(cyc));
            set_alu(4'd10, 32'hBEEF0000 + 32'(cyc));
            tick();
        end
        check("mid_stall_pre", 32'(stall), 32'd1);
        idle_inputs();
        rst = 1'b0;
        #1;
        $display("reset asserted with queue occupied");
        check("mid_wb",    32'(wb),    32'd0);
        check("mid_stall", 32'(stall), 32'd0);
        check("mid_r",     32'(wb_r),  32'd0);
        check("mid_data",  wb_data,    32'd0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_wb%0d", i), 32'(wb), 32'd0);
        end

        // Normal operation resumes after reset
        set_alu(4'd7, 32'h77);
        tick();
        idle_inputs();
        check("resume_wb", 32'(wb),   32'd1);
        check("resume_r",  32'(wb_r), 32'd7);
        check("resume_d",  wb_data,   32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
